aes_host_link: RTL

- Host-side counterpart of the AES core's 64-bit input/output buffering.
- Accepts one 128-bit plaintext state and 128-bit key per operation.
- Serializes them as four 64-bit beats over a valid/ready link toward the input buffer.
- Then collects the two 64-bit result beats returned by the output buffer, reassembles the 128-bit ciphertext, and reports completion or timeout.

---
 rtl/aes_link_pkg.sv | 16 +
 rtl/link_timeout_cnt.sv | 30 +++
 rtl/aes_host_link.sv | 135 +++++++++++++
 3 files changed

// File: rtl/aes_link_pkg.sv
// Shared definitions for the AES host link and its buffer-side helpers.
package aes_link_pkg;

   localparam int unsigned DEF_DATA_W  = 64;
   localparam int unsigned DEF_BLOCK_W = 128;
   localparam int unsigned TX_BEATS    = 4;
   localparam int unsigned RX_BEATS    = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_RES = 2'd2,
      DONE     = 2'd3
   } link_state_t;

endpackage : aes_link_pkg

// File: rtl/link_timeout_cnt.sv
// Clear/increment idle counter; o_expired marks the idle cycle whose
// increment brings the count to TIMEOUT, so the owner can abort on that edge.
module link_timeout_cnt #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_expired = i_inc && !i_clr && (r_cnt == CNT_W'(TIMEOUT - 1));

   // count idle cycles, saturating at TIMEOUT so the counter never wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CNT_W'(TIMEOUT))) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule : link_timeout_cnt

// File: rtl/aes_host_link.sv
// Host-side AES link: sends state+key as four beats, collects the two
// result beats, and reports completion or an idle timeout.
module aes_host_link
   import aes_link_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned BLOCK_W = DEF_BLOCK_W,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BLOCK_W-1:0] state_in,
   input  logic [BLOCK_W-1:0] key_in,
   output logic               busy,
   output logic [DATA_W-1:0]  tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   input  logic [DATA_W-1:0]  rx_data,
   input  logic               rx_valid,
   output logic [BLOCK_W-1:0] result,
   output logic               done,
   output logic               timeout_err
);

   link_state_t        r_state;
   logic [BLOCK_W-1:0] r_st;
   logic [BLOCK_W-1:0] r_key;
   logic [1:0]         r_tx_idx;
   logic               r_rx_idx;
   logic [DATA_W-1:0]  r_tx_data;
   logic               r_tx_valid;
   logic [BLOCK_W-1:0] r_result;
   logic               r_done;
   logic               r_err;

   logic w_tmo_clr;
   logic w_tmo_inc;
   logic w_tmo_expired;

   function automatic logic [DATA_W-1:0] beat_sel(
      input logic [BLOCK_W-1:0] st,
      input logic [BLOCK_W-1:0] ky,
      input logic [1:0]         idx
   );
      logic [DATA_W-1:0] w_beat;
      case (idx)
         2'd0:    w_beat = st[BLOCK_W-1:DATA_W];
         2'd1:    w_beat = st[DATA_W-1:0];
         2'd2:    w_beat = ky[BLOCK_W-1:DATA_W];
         default: w_beat = ky[DATA_W-1:0];
      endcase
      return w_beat;
   endfunction

   assign w_tmo_inc = (r_state == WAIT_RES) && !rx_valid;
   assign w_tmo_clr = (r_state != WAIT_RES) || rx_valid;

   link_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_tmo_clr),
      .i_inc     (w_tmo_inc),
      .o_expired (w_tmo_expired)
   );

   assign busy        = (r_state != IDLE);
   assign tx_data     = r_tx_data;
   assign tx_valid    = r_tx_valid;
   assign result      = r_result;
   assign done        = r_done;
   assign timeout_err = r_err;

   // operation sequencer with registered link outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_st       <= '0;
         r_key      <= '0;
         r_tx_idx   <= '0;
         r_rx_idx   <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_result   <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_st       <= state_in;
                  r_key      <= key_in;
                  r_err      <= 1'b0;
                  r_tx_idx   <= '0;
                  r_tx_data  <= beat_sel(state_in, key_in, 2'd0);
                  r_tx_valid <= 1'b1;
                  r_state    <= SEND;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  if (r_tx_idx == 2'(TX_BEATS - 1)) begin
                     r_tx_valid <= 1'b0;
                     r_rx_idx   <= '0;
                     r_state    <= WAIT_RES;
                  end else begin
                     r_tx_idx  <= r_tx_idx + 2'd1;
                     r_tx_data <= beat_sel(r_st, r_key, r_tx_idx + 2'd1);
                  end
               end
            end
            WAIT_RES: begin
               if (rx_valid) begin
                  if (r_rx_idx == 1'(RX_BEATS - 1)) begin
                     r_result[DATA_W-1:0] <= rx_data;
                     r_done               <= 1'b1;
                     r_state              <= DONE;
                  end else begin
                     r_result[BLOCK_W-1:DATA_W] <= rx_data;
                     r_rx_idx                   <= 1'b1;
                  end
               end else if (w_tmo_expired) begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : aes_host_link
